// File: rtl/p4_router_egress_demux.sv
// Egress demux behind the VNP4 pipeline: steers each packet to one
// RTL egress port using a metadata FIFO keyed by egress ID.
module p4_router_egress_demux #(
  parameter int DATA_BYTES          = 8,
  parameter int USER_METADATA_WIDTH = 16,
  parameter int NUM_EGRESS          = 11,
  parameter int MD_FIFO_DEPTH       = 8
) (
  input  logic                              clk,
  input  logic                              sreset,
  input  logic [8*DATA_BYTES-1:0]           s_axis_tdata,
  input  logic [DATA_BYTES-1:0]             s_axis_tkeep,
  input  logic                              s_axis_tlast,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [USER_METADATA_WIDTH-1:0]    user_metadata_in,
  input  logic                              user_metadata_in_valid,
  output logic [NUM_EGRESS*8*DATA_BYTES-1:0] m_axis_tdata,
  output logic [NUM_EGRESS*DATA_BYTES-1:0]  m_axis_tkeep,
  output logic [NUM_EGRESS-1:0]             m_axis_tlast,
  output logic [NUM_EGRESS-1:0]             m_axis_tvalid,
  input  logic [NUM_EGRESS-1:0]             m_axis_tready,
  output logic [7:0]                        m_ingress_id,
  output logic [31:0]                       drop_count,
  output logic                              md_overflow
);

  localparam int AW = $clog2(MD_FIFO_DEPTH);
  localparam logic [8:0] NE = 9'(NUM_EGRESS);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;

  state_e        state_q, state_d;
  logic [7:0]    sel_q, sel_d;
  logic [7:0]    ing_q, ing_d;
  logic [31:0]   drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]   mem_q [MD_FIFO_DEPTH];

  logic          empty, full, push, pop;
  logic [15:0]   head;
  logic          sel_ready;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Broadcast payload; only tvalid is qualified per port
  assign m_axis_tdata = {NUM_EGRESS{s_axis_tdata}};
  assign m_axis_tkeep = {NUM_EGRESS{s_axis_tkeep}};
  assign m_axis_tlast = {NUM_EGRESS{s_axis_tlast}};

  assign m_ingress_id = ing_q;
  assign drop_count   = drop_q;
  assign md_overflow  = ovf_q;

  // Route valid to the selected port and take ready back from it
  always_comb begin
    m_axis_tvalid = '0;
    sel_ready     = 1'b0;
    for (int i = 0; i < NUM_EGRESS; i++) begin
      if (state_q == FWD && sel_q == 8'(i)) begin
        m_axis_tvalid[i] = s_axis_tvalid;
        sel_ready        = m_axis_tready[i];
      end
    end
  end

  assign s_axis_tready = (state_q == FWD) ? sel_ready
                                          : (state_q == DROP);

  // Packet FSM: pop metadata on packet start, then forward or drop
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ing_d   = ing_q;
    drop_d  = drop_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && s_axis_tvalid) begin
          pop     = 1'b1;
          sel_d   = head[15:8];
          ing_d   = head[7:0];
          state_d = ({1'b0, head[15:8]} < NE) ? FWD : DROP;
        end
      end
      FWD: begin
        if (s_axis_tvalid && sel_ready && s_axis_tlast)
          state_d = IDLE;
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = IDLE;
          if (drop_q != 32'hFFFF_FFFF)
            drop_d = drop_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Metadata FIFO control; a full FIFO still takes a push if it pops
  always_comb begin
    push     = user_metadata_in_valid && (!full || pop);
    ovf_d    = ovf_q | (user_metadata_in_valid && full && !pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  // State and pointer registers
  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      ing_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ing_q    <= ing_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage holds {egress_id, ingress_id}
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q[AW-1:0]] <= user_metadata_in[15:0];
  end

endmodule

// File: tb/tb_p4_router_egress_demux.sv
// Directed bench for the egress demux: routing, drop, backpressure,
// metadata overflow and mid-packet reset.
module tb_p4_router_egress_demux;

  localparam int DB = 8;
  localparam int NE = 11;
  localparam int DW = 8 * DB;

  logic                 clk = 1'b0;
  logic                 sreset;
  logic [DW-1:0]        s_axis_tdata;
  logic [DB-1:0]        s_axis_tkeep;
  logic                 s_axis_tlast;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic [15:0]          user_metadata_in;
  logic                 user_metadata_in_valid;
  logic [NE*DW-1:0]     m_axis_tdata;
  logic [NE*DB-1:0]     m_axis_tkeep;
  logic [NE-1:0]        m_axis_tlast;
  logic [NE-1:0]        m_axis_tvalid;
  logic [NE-1:0]        m_axis_tready;
  logic [7:0]           m_ingress_id;
  logic [31:0]          drop_count;
  logic                 md_overflow;

  int n_chk = 0;
  int n_fail = 0;
  int onehot_err = 0;

  int          log_port[$];
  logic [63:0] log_data[$];
  logic        log_last[$];

  p4_router_egress_demux #(
    .DATA_BYTES(DB), .USER_METADATA_WIDTH(16),
    .NUM_EGRESS(NE), .MD_FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .sreset(sreset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .user_metadata_in(user_metadata_in),
    .user_metadata_in_valid(user_metadata_in_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_ingress_id(m_ingress_id),
    .drop_count(drop_count), .md_overflow(md_overflow)
  );

  always #5 clk = ~clk;

  // Record every beat handed to an egress port
  always @(negedge clk) begin
    if (!sreset) begin
      for (int i = 0; i < NE; i++) begin
        if (m_axis_tvalid[i] && m_axis_tready[i]) begin
          log_port.push_back(i);
          log_data.push_back(m_axis_tdata[i*DW +: DW]);
          log_last.push_back(m_axis_tlast[i]);
        end
      end
    end
    if ($countones(m_axis_tvalid) > 1) onehot_err++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic md(input logic [7:0] eg, input logic [7:0] ig);
    user_metadata_in       = {eg, ig};
    user_metadata_in_valid = 1'b1;
    tick();
    user_metadata_in_valid = 1'b0;
  endtask

  task automatic send(input int n, input logic [63:0] base,
                      output int cyc);
    logic acc;
    cyc = 0;
    for (int b = 0; b < n; b++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = base + 64'(b);
      s_axis_tlast  = (b == n - 1);
      acc = 1'b0;
      while (!acc && cyc < 200) begin
        @(negedge clk);
        acc = s_axis_tready;
        tick();
        cyc++;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("send_timeout", 64'(cyc < 200), 64'd1);
  endtask

  task automatic chk_beat(input string tag, input int idx, input int port,
                          input logic [63:0] data, input logic last);
    if (idx >= log_port.size()) begin
      chk({tag, "_count"}, 64'(log_port.size()), 64'(idx + 1));
    end else begin
      chk($sformatf("%s_port%0d", tag, idx), 64'(log_port[idx]), 64'(port));
      chk($sformatf("%s_data%0d", tag, idx), log_data[idx], data);
      chk($sformatf("%s_last%0d", tag, idx), 64'(log_last[idx]), 64'(last));
    end
  endtask

  task automatic clr_log();
    log_port.delete();
    log_data.delete();
    log_last.delete();
  endtask

  task automatic chk_reset(input string tag);
    @(negedge clk);
    chk({tag, "_tready"}, 64'(s_axis_tready), 64'd0);
    chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_ingress"}, 64'(m_ingress_id), 64'd0);
    chk({tag, "_drops"}, 64'(drop_count), 64'd0);
    chk({tag, "_ovf"}, 64'(md_overflow), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int b;
    int k;
    int stall;
    logic [3:0] pat;

    sreset = 1'b1;
    s_axis_tdata = '0;
    s_axis_tkeep = '1;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b0;
    user_metadata_in = '0;
    user_metadata_in_valid = 1'b0;
    m_axis_tready = '1;
    tick();
    tick();
    sreset = 1'b0;
    chk_reset("rst");

    // 1: four beats to port 3 with one bubble
    clr_log();
    md(8'd3, 8'd20);
    send(4, 64'h100, cyc);
    chk("t1_cycles", 64'(cyc), 64'd5);
    chk("t1_nbeats", 64'(log_port.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk_beat("t1", i, 3, 64'h100 + 64'(i), i == 3);
    chk("t1_ingress", 64'(m_ingress_id), 64'd20);

    // 2: back-to-back metadata, three single-beat packets
    clr_log();
    md(8'd0, 8'd1);
    md(8'd10, 8'd2);
    md(8'd5, 8'd3);
    for (int i = 0; i < 3; i++) begin
      send(1, 64'h200 + 64'(i), cyc);
      chk("t2_cycles", 64'(cyc), 64'd2);
    end
    chk_beat("t2", 0, 0, 64'h200, 1'b1);
    chk_beat("t2", 1, 10, 64'h201, 1'b1);
    chk_beat("t2", 2, 5, 64'h202, 1'b1);
    chk("t2_drops", 64'(drop_count), 64'd0);
    chk("t2_ingress", 64'(m_ingress_id), 64'd3);

    // 3: egress 0xFF dropped, then port 1
    clr_log();
    md(8'hFF, 8'd4);
    send(3, 64'h300, cyc);
    chk("t3_drop_cycles", 64'(cyc), 64'd4);
    chk("t3_drops", 64'(drop_count), 64'd1);
    chk("t3_nolog", 64'(log_port.size()), 64'd0);
    md(8'd1, 8'd5);
    send(2, 64'h400, cyc);
    chk("t3_nbeats", 64'(log_port.size()), 64'd2);
    chk_beat("t3", 0, 1, 64'h400, 1'b0);
    chk_beat("t3", 1, 1, 64'h401, 1'b1);
    chk("t3_ingress", 64'(m_ingress_id), 64'd5);

    // 4: backpressure on port 7 with pattern 1,0,0,1
    clr_log();
    md(8'd7, 8'd6);
    m_axis_tready = '0;
    pat = 4'b1001;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'h500;
    s_axis_tlast = 1'b0;
    @(negedge clk);
    chk("t4_bubble", 64'(s_axis_tready), 64'd0);
    tick();
    b = 0;
    k = 0;
    while (b < 5 && k < 40) begin
      m_axis_tready[7] = pat[k % 4];
      @(negedge clk);
      chk("t4_mirror", 64'(s_axis_tready), 64'(pat[k % 4]));
      tick();
      if (pat[k % 4]) begin
        b++;
        s_axis_tdata = 64'h500 + 64'(b);
        s_axis_tlast = (b == 4);
      end
      k++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    m_axis_tready = '1;
    chk("t4_cycles", 64'(k), 64'd9);
    chk("t4_nbeats", 64'(log_port.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk_beat("t4", i, 7, 64'h500 + 64'(i), i == 4);

    // 5: nine metadata pulses overflow the 8-entry FIFO
    clr_log();
    for (int i = 1; i <= 9; i++)
      md(8'(i), 8'(i));
    chk("t5_ovf", 64'(md_overflow), 64'd1);
    for (int i = 1; i <= 8; i++)
      send(1, 64'h600 + 64'(i), cyc);
    chk("t5_nbeats", 64'(log_port.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk_beat("t5", i, i + 1, 64'h601 + 64'(i), 1'b1);
    chk("t5_ingress", 64'(m_ingress_id), 64'd8);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'h609;
    s_axis_tlast = 1'b1;
    stall = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!s_axis_tready) stall++;
      tick();
    end
    chk("t5_stall", 64'(stall), 64'd6);
    chk("t5_ovf_sticky", 64'(md_overflow), 64'd1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;

    // 6: reset on beat 2 of a forwarded packet
    md(8'd4, 8'd8);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'h700;
    s_axis_tlast = 1'b0;
    tick();
    tick();
    s_axis_tdata = 64'h701;
    sreset = 1'b1;
    tick();
    sreset = 1'b0;
    s_axis_tdata = 64'h702;
    chk_reset("t6_rst");
    clr_log();
    md(8'd2, 8'd9);
    send(2, 64'h702, cyc);
    chk("t6_cycles", 64'(cyc), 64'd3);
    chk("t6_nbeats", 64'(log_port.size()), 64'd2);
    chk_beat("t6", 0, 2, 64'h702, 1'b0);
    chk_beat("t6", 1, 2, 64'h703, 1'b1);
    chk("t6_ingress", 64'(m_ingress_id), 64'd9);

    chk("onehot_valid", 64'(onehot_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/p4_router_egress_demux.md
Name: p4_router_egress_demux

Overview:
Consumes the packet stream and per-packet user metadata leaving the VNP4 P4 pipeline, and steers each packet to one of NUM_EGRESS RTL egress ports. The steering key is the RTL egress ID in the metadata; the ingress ID is forwarded alongside the data. The block sits between the VNP4 wrapper output and the per-port egress queues (CPU, OISL, ECP, HDR, ECG). Packets whose egress ID is out of range (including 0xFF) are dropped and counted.

Parameters:
DATA_BYTES, 8, AXIS data width in bytes; tdata is 8*DATA_BYTES bits.
USER_METADATA_WIDTH, 16, metadata width; bits [15:8] hold the egress ID and [7:0] the ingress ID; must be at least 16.
NUM_EGRESS, 11, number of egress ports; valid IDs are 0..NUM_EGRESS-1; must be between 2 and 255.
MD_FIFO_DEPTH, 8, metadata FIFO depth; must be a power of 2 and at least 2.

Ports:
clk  in  1  block clock (the AXIS clock of the VNP4)
sreset  in  1  synchronous reset, active-high
s_axis_tdata  in  8*DATA_BYTES  stream from VNP4
s_axis_tkeep  in  DATA_BYTES  byte enables
s_axis_tlast  in  1  end of packet
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  beat accepted
user_metadata_in  in  USER_METADATA_WIDTH  per-packet metadata from VNP4
user_metadata_in_valid  in  1  one-cycle pulse, once per packet, no backpressure
m_axis_tdata  out  NUM_EGRESS*8*DATA_BYTES  per-port data (broadcast copy)
m_axis_tkeep  out  NUM_EGRESS*DATA_BYTES  per-port keep (broadcast copy)
m_axis_tlast  out  NUM_EGRESS  per-port last
m_axis_tvalid  out  NUM_EGRESS  per-port valid; at most one bit high at a time
m_axis_tready  in  NUM_EGRESS  per-port ready
m_ingress_id  out  8  ingress ID of the packet currently being forwarded
drop_count  out  32  packets dropped; saturates at 0xFFFFFFFF
md_overflow  out  1  sticky: metadata arrived while the FIFO was full

Behaviour:
- Reset values:
  - s_axis_tready=0, all m_axis_tvalid=0, m_ingress_id=0.
  - drop_count=0, md_overflow=0.
  - Metadata FIFO empty, FSM in IDLE.
- Metadata FIFO:
  - Pushes {egress_id, ingress_id} when user_metadata_in_valid=1.
  - When full:
    - A push is accepted only if a pop happens in the same cycle.
    - Otherwise the entry is discarded and md_overflow is set; it stays set until sreset.
  - Ordering is FIFO. Metadata may arrive before, with, or after the first beat of its packet.
- FSM states: IDLE, FWD, DROP.
  - IDLE:
    - s_axis_tready=0.
    - When the FIFO is non-empty and s_axis_tvalid=1: pop the head entry and latch sel=egress_id and ingress_id into m_ingress_id.
    - If sel<NUM_EGRESS, go to FWD; otherwise go to DROP.
    - This costs one bubble cycle per packet.
    - If s_axis_tvalid=1 while the FIFO is empty, stall indefinitely. There is no timeout.
  - FWD:
    - m_axis_tvalid[sel]=s_axis_tvalid and s_axis_tready=m_axis_tready[sel]; the path is combinational with zero latency.
    - tdata/tkeep/tlast are broadcast to all ports; only the valid bit is qualified.
    - On an accepted beat with tlast=1, go to IDLE.
    - A single-beat packet spends one cycle in FWD.
  - DROP:
    - s_axis_tready=1 and all m_axis_tvalid=0.
    - On an accepted beat with tlast=1, increment drop_count (saturating) and go to IDLE.
- sel and m_ingress_id hold stable from entry into FWD until that state is exited.
- Backpressure:
  - m_axis_tready on non-selected ports is ignored.
  - Deasserting the selected port's tready stalls the input; no beat is lost or duplicated.
- Reset mid-packet: return to reset values. The FIFO is cleared, and the next s_axis beat is treated as a packet start.

Test Plan:
1. Metadata {egress=3, ingress=20} pulsed, then a 4-beat packet with all ready -> all 4 beats on port 3 only; m_ingress_id=20; one bubble cycle before the first beat; port 3 tlast on beat 4.
2. Metadata egress IDs 0, 10, 5 pushed back-to-back, then three 1-beat packets -> delivered in order to ports 0, 10, 5; drop_count=0.
3. Metadata egress=0xFF with a 3-beat packet, then egress=1 with a 2-beat packet -> first packet consumed with no m_axis_tvalid; drop_count=1; second packet on port 1.
4. Port 7 selected, m_axis_tready[7] toggled 1,0,0,1 during a 5-beat packet; other readies held at 0 -> s_axis_tready mirrors ready[7]; exactly 5 beats delivered, in order, on port 7.
5. 9 metadata pulses with no stream traffic (depth 8) -> md_overflow=1; the first 8 packets route per entries 1..8; a 9th stream packet stalls with s_axis_tready=0.
6. sreset asserted for 1 cycle on beat 2 of a 4-beat FWD packet -> outputs return to reset values; FIFO empty; new metadata {egress=2} with the next beats routes to port 2.
